// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, NOP encoding and fetch stride.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'd0;
    localparam int PC_STEP = 4;

    typedef logic [XLEN-1:0] instr_t;

endpackage

// File: rtl/instr_issue_queue.sv
// Multi-lane instruction queue between instruction fetch and the scheduler.
// Fetches one word per cycle, buffers it in a circular FIFO and shows the ISSUE_W oldest entries.
module instr_issue_queue #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int DEPTH = 8,
    parameter int ISSUE_W = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int ICW = $clog2(ISSUE_W + 1)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    output logic [XLEN-1:0]         fetch_pc,
    input  logic                    fetch_valid,
    output logic                    fetch_ready,
    input  logic [XLEN-1:0]         fetch_instr,
    output logic [ISSUE_W*XLEN-1:0] issue_instr,
    output logic [ISSUE_W-1:0]      issue_valid,
    input  logic [ICW-1:0]          issue_cnt,
    input  logic                    flush,
    input  logic [XLEN-1:0]         flush_pc,
    output logic                    nothing_filled,
    output logic [CNT_W-1:0]        count
);
    import cpu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_fetch_pc;

    logic             w_enq;
    logic [CNT_W-1:0] w_issue_ext;
    logic [CNT_W-1:0] w_eff;

    // Acceptance looks only at the pre-cycle occupancy, so a full queue refuses even while draining.
    assign fetch_ready    = (r_count != CNT_W'(DEPTH));
    assign w_enq          = fetch_valid && fetch_ready && !flush;
    assign w_issue_ext    = CNT_W'(issue_cnt);
    assign w_eff          = (w_issue_ext > r_count) ? r_count : w_issue_ext;
    assign fetch_pc       = r_fetch_pc;
    assign count          = r_count;
    assign nothing_filled = (r_count == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
        end else if (flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= flush_pc;
        end else begin
            r_head  <= r_head + PTR_W'(w_eff);
            r_count <= r_count + CNT_W'(w_enq) - w_eff;
            if (w_enq) begin
                r_tail     <= r_tail + 1'b1;
                r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
            end
        end
    end

    // Storage carries no reset; validity is defined entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= fetch_instr;
        end
    end

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
        logic [PTR_W-1:0] w_idx;
        logic             w_valid;

        assign w_idx   = r_head + PTR_W'(i);
        assign w_valid = (CNT_W'(i) < r_count);
        assign issue_valid[i] = w_valid;
        assign issue_instr[i*XLEN +: XLEN] = w_valid ? r_mem[w_idx] : XLEN'(NOP_INSTR);
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: accepted fetch words go into a scoreboard queue,
// a monitor pops and compares them as the scheduler consumes lanes.
module tb_instr_issue_queue;

    logic        clk;
    logic        n_rst;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [63:0] issue_instr;
    logic [1:0]  issue_valid;
    logic [1:0]  issue_cnt;
    logic        flush;
    logic [31:0] flush_pc;
    logic        nothing_filled;
    logic [3:0]  count;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    instr_issue_queue dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .fetch_pc       (fetch_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_instr    (fetch_instr),
        .issue_instr    (issue_instr),
        .issue_valid    (issue_valid),
        .issue_cnt      (issue_cnt),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .nothing_filled (nothing_filled),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input bit v, input logic [31:0] w, input bit accepted);
        fetch_valid = v;
        fetch_instr = w;
        if (v && accepted) exp_q.push_back(w);
    endtask

    // Monitor: on each negedge, lanes about to be consumed are checked against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (n_rst && !flush && issue_cnt != 2'd0) begin
                for (int i = 0; i < int'(issue_cnt) && i < 2; i++) begin
                    if (issue_valid[i]) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL issue_lane%0d: got %h expected no entry", i, issue_instr[i*32 +: 32]);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("issue_lane%0d", i), issue_instr[i*32 +: 32], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst = 1'b0;
        fetch_valid = 1'b0;
        fetch_instr = '0;
        issue_cnt = '0;
        flush = 1'b0;
        flush_pc = '0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(nothing_filled), 32'd1);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_pc", fetch_pc, 32'h0);
        step();
        n_rst = 1'b1;

        // First two fetches
        fetch(1, 32'h0050_0093, 1);
        step();
        chk("one_count", 32'(count), 32'd1);
        chk("one_valid", 32'(issue_valid), 32'd1);
        chk("one_lane1_nop", issue_instr[63:32], 32'h0);
        fetch(1, 32'h00A0_0113, 1);
        step();
        fetch(0, 32'h0, 0);
        chk("two_count", 32'(count), 32'd2);
        chk("two_valid", 32'(issue_valid), 32'd3);
        chk("two_lane0", issue_instr[31:0], 32'h0050_0093);
        chk("two_lane1", issue_instr[63:32], 32'h00A0_0113);
        chk("two_pc", fetch_pc, 32'h8);

        // Fill to DEPTH
        for (int k = 0; k < 6; k++) begin
            fetch(1, 32'h1000_0000 + 32'(k), 1);
            step();
        end
        fetch(0, 32'h0, 0);
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(fetch_ready), 32'd0);
        chk("full_pc", fetch_pc, 32'h20);
        fetch(1, 32'hDEAD_BEEF, 0);
        step();
        chk("full_reject_count", 32'(count), 32'd8);
        chk("full_reject_pc", fetch_pc, 32'h20);
        // Full and consuming: still no accept
        issue_cnt = 2'd1;
        step();
        fetch(0, 32'h0, 0);
        chk("full_consume_count", 32'(count), 32'd7);
        chk("full_consume_pc", fetch_pc, 32'h20);
        chk("full_consume_ready", 32'(fetch_ready), 32'd1);

        // Drain down to 3, then consume one
        issue_cnt = 2'd2;
        step();
        chk("drain_count5", 32'(count), 32'd5);
        step();
        chk("drain_count3", 32'(count), 32'd3);
        issue_cnt = 2'd1;
        step();
        chk("consume1_count", 32'(count), 32'd2);
        chk("consume1_lane0", issue_instr[31:0], 32'h1000_0004);

        // Head at 7: lanes span the wrap
        fetch(1, 32'h0000_A001, 1);
        step();
        fetch(0, 32'h0, 0);
        chk("wrap_count", 32'(count), 32'd2);
        chk("wrap_lane0", issue_instr[31:0], 32'h1000_0005);
        chk("wrap_lane1", issue_instr[63:32], 32'h0000_A001);
        issue_cnt = 2'd2;
        step();
        issue_cnt = 2'd0;
        chk("wrap_drain_count", 32'(count), 32'd0);
        fetch(1, 32'h0000_B002, 1);
        step();
        fetch(0, 32'h0, 0);
        chk("head1_count", 32'(count), 32'd1);
        chk("head1_lane0", issue_instr[31:0], 32'h0000_B002);

        // Clamped consume
        issue_cnt = 2'd2;
        step();
        issue_cnt = 2'd0;
        chk("clamp_count", 32'(count), 32'd0);
        chk("clamp_empty", 32'(nothing_filled), 32'd1);
        chk("clamp_valid", 32'(issue_valid), 32'd0);
        chk("clamp_lane0", issue_instr[31:0], 32'h0);
        chk("clamp_lane1", issue_instr[63:32], 32'h0);

        // Flush with simultaneous fetch and consume
        for (int k = 0; k < 5; k++) begin
            fetch(1, 32'h2000_0000 + 32'(k), 1);
            step();
        end
        fetch(0, 32'h0, 0);
        chk("preflush_count", 32'(count), 32'd5);
        chk("preflush_pc", fetch_pc, 32'h3C);
        flush = 1'b1;
        flush_pc = 32'h100;
        issue_cnt = 2'd2;
        fetch(1, 32'h0BAD_0BAD, 0);
        exp_q.delete();
        step();
        flush = 1'b0;
        issue_cnt = 2'd0;
        fetch(0, 32'h0, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_pc", fetch_pc, 32'h100);
        chk("flush_empty", 32'(nothing_filled), 32'd1);
        chk("flush_valid", 32'(issue_valid), 32'd0);
        fetch(1, 32'h3000_0001, 1);
        step();
        fetch(0, 32'h0, 0);
        chk("postflush_count", 32'(count), 32'd1);
        chk("postflush_lane0", issue_instr[31:0], 32'h3000_0001);
        chk("postflush_pc", fetch_pc, 32'h104);
        issue_cnt = 2'd1;
        step();
        issue_cnt = 2'd0;
        chk("postflush_drain", 32'(count), 32'd0);

        // Asynchronous reset mid-stream
        fetch(1, 32'h4000_0000, 1);
        step();
        fetch(1, 32'h4000_0001, 0);
        #2;
        n_rst = 1'b0;
        #1;
        exp_q.delete();
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_pc", fetch_pc, 32'h0);
        chk("async_rst_empty", 32'(nothing_filled), 32'd1);
        chk("async_rst_ready", 32'(fetch_ready), 32'd1);
        fetch(0, 32'h0, 0);
        step();
        n_rst = 1'b1;
        step();
        chk("after_rst_count", 32'(count), 32'd0);
        chk("after_rst_valid", 32'(issue_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
